// File: rtl/block_serializer_if.sv
// Parallel result-set input and one-coefficient-per-beat output of block_serializer.
// With BLKSER_DROP_CNT_EN defined the interface also carries the drop_cnt counter.
interface block_serializer_if #(
   parameter int DATA_W   = 12,
   parameter int BLK_ELEM = 9
);
   logic                       in_valid;
   logic [DATA_W*BLK_ELEM-1:0] block_in_0;
   logic [DATA_W*BLK_ELEM-1:0] block_in_1;
   logic [DATA_W*BLK_ELEM-1:0] block_in_2;
   logic [DATA_W*BLK_ELEM-1:0] block_in_3;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_W-1:0]          out_data;
   logic [1:0]                 out_blk;
   logic [3:0]                 out_idx;
   logic                       out_last;
   logic                       overflow;
`ifdef BLKSER_DROP_CNT_EN
   logic [15:0]                drop_cnt;
`endif

   modport master (
      input  in_valid, block_in_0, block_in_1, block_in_2, block_in_3, out_ready,
`ifdef BLKSER_DROP_CNT_EN
      output drop_cnt,
`endif
      output out_valid, out_data, out_blk, out_idx, out_last, overflow
   );

   modport slave (
      output in_valid, block_in_0, block_in_1, block_in_2, block_in_3, out_ready,
`ifdef BLKSER_DROP_CNT_EN
      input  drop_cnt,
`endif
      input  out_valid, out_data, out_blk, out_idx, out_last, overflow
   );
endinterface

// File: rtl/block_serializer.sv
// Buffers DEPTH pulsed result sets (4 blocks x 9 coeffs) and streams them one coefficient per beat.
// Optional feature macro BLKSER_DROP_CNT_EN adds a saturating 16-bit dropped-set counter.
module block_serializer #(
   parameter int DATA_W   = 12,
   parameter int NUM_BLK  = 4,
   parameter int BLK_ELEM = 9,
   parameter int DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   block_serializer_if.master bus
);
   localparam int         VEC_W    = DATA_W * BLK_ELEM;
   localparam int         PTR_W    = $clog2(DEPTH);
   localparam int         CNT_W    = $clog2(DEPTH + 1);
   localparam logic [1:0] LAST_BLK = 2'(NUM_BLK - 1);
   localparam logic [3:0] LAST_IDX = 4'(BLK_ELEM - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   function automatic logic [DATA_W-1:0] coeff_sel(input logic [VEC_W-1:0] vec,
                                                   input logic [3:0]       idx);
      logic [DATA_W-1:0] res;
      res = {DATA_W{1'b0}};
      for (int k = 0; k < BLK_ELEM; k++) begin
         res = (idx == 4'(k)) ? vec[DATA_W*k +: DATA_W] : res;
      end
      return res;
   endfunction

   logic [VEC_W-1:0]  mem_r [DEPTH][NUM_BLK];
   logic [VEC_W-1:0]  blk_in_s [NUM_BLK];
   logic [PTR_W-1:0]  wptr_r, rptr_r, rptr_inc_s;
   logic [CNT_W-1:0]  count_r, count_nxt_s;
   state_t            state_r, state_nxt_s;
   logic              full_s, push_s, pop_s, drop_s;
   logic [1:0]        adv_blk_s;
   logic [3:0]        adv_idx_s;
   logic              out_valid_r, valid_nxt_s;
   logic [DATA_W-1:0] out_data_r, data_nxt_s;
   logic [1:0]        out_blk_r, blk_nxt_s;
   logic [3:0]        out_idx_r, idx_nxt_s;
   logic              out_last_r, last_nxt_s;
   logic              overflow_r;

   assign blk_in_s[0] = bus.block_in_0;
   assign blk_in_s[1] = bus.block_in_1;
   assign blk_in_s[2] = bus.block_in_2;
   assign blk_in_s[3] = bus.block_in_3;

   // A completing head set frees its slot in the same cycle, so a full buffer can still accept.
   assign full_s     = (count_r == CNT_W'(DEPTH));
   assign pop_s      = out_valid_r & bus.out_ready & out_last_r;
   assign push_s     = bus.in_valid & (~full_s | pop_s);
   assign drop_s     = bus.in_valid & full_s & ~pop_s;
   assign rptr_inc_s = rptr_r + PTR_W'(1'b1);

   // Occupancy after this cycle's push and pop.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Position of the beat following the one currently presented.
   always_comb begin
      if (out_idx_r == LAST_IDX) begin
         adv_blk_s = out_blk_r + 2'd1;
         adv_idx_s = 4'd0;
      end else begin
         adv_blk_s = out_blk_r;
         adv_idx_s = out_idx_r + 4'd1;
      end
   end

   // Next state and next output beat; an empty buffer forwards a new set's first coeff directly.
   always_comb begin
      state_nxt_s = state_r;
      valid_nxt_s = out_valid_r;
      data_nxt_s  = out_data_r;
      blk_nxt_s   = out_blk_r;
      idx_nxt_s   = out_idx_r;
      last_nxt_s  = out_last_r;
      case (state_r)
         IDLE: begin
            if (push_s) begin
               state_nxt_s = SEND;
               valid_nxt_s = 1'b1;
               data_nxt_s  = coeff_sel(blk_in_s[0], 4'd0);
               blk_nxt_s   = 2'd0;
               idx_nxt_s   = 4'd0;
               last_nxt_s  = 1'b0;
            end else begin
               valid_nxt_s = 1'b0;
            end
         end
         SEND: begin
            if (bus.out_ready & out_last_r) begin
               blk_nxt_s  = 2'd0;
               idx_nxt_s  = 4'd0;
               last_nxt_s = 1'b0;
               if (count_r > CNT_W'(1'b1)) begin
                  valid_nxt_s = 1'b1;
                  data_nxt_s  = coeff_sel(mem_r[rptr_inc_s][2'd0], 4'd0);
               end else if (push_s) begin
                  valid_nxt_s = 1'b1;
                  data_nxt_s  = coeff_sel(blk_in_s[0], 4'd0);
               end else begin
                  state_nxt_s = IDLE;
                  valid_nxt_s = 1'b0;
               end
            end else if (bus.out_ready) begin
               blk_nxt_s  = adv_blk_s;
               idx_nxt_s  = adv_idx_s;
               last_nxt_s = (adv_blk_s == LAST_BLK) && (adv_idx_s == LAST_IDX);
               data_nxt_s = coeff_sel(mem_r[rptr_r][adv_blk_s], adv_idx_s);
            end else begin
               state_nxt_s = SEND;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_nxt_s;
   end

   // Result-set storage; not reset, validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wptr_r] <= blk_in_s;
   end

   // Buffer pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r  <= {PTR_W{1'b0}};
         rptr_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         if (push_s) wptr_r <= wptr_r + PTR_W'(1'b1);
         if (pop_s)  rptr_r <= rptr_inc_s;
         count_r <= count_nxt_s;
      end
   end

   // Registered output beat and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_blk_r   <= 2'd0;
         out_idx_r   <= 4'd0;
         out_last_r  <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         out_valid_r <= valid_nxt_s;
         out_data_r  <= data_nxt_s;
         out_blk_r   <= blk_nxt_s;
         out_idx_r   <= idx_nxt_s;
         out_last_r  <= last_nxt_s;
         if (drop_s) overflow_r <= 1'b1;
      end
   end

`ifdef BLKSER_DROP_CNT_EN
   logic [15:0] drop_cnt_r;

   // Saturating count of dropped sets.
   always_ff @(posedge clk) begin
      if (rst)                                drop_cnt_r <= 16'd0;
      else if (drop_s && drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
   end

   assign bus.drop_cnt = drop_cnt_r;
`endif

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_blk   = out_blk_r;
   assign bus.out_idx   = out_idx_r;
   assign bus.out_last  = out_last_r;
   assign bus.overflow  = overflow_r;
endmodule
